// File: rtl/note_display_pkg.sv
// Shared note codes, seven-segment glyphs and digit roles for the note display.
package note_display_pkg;

    localparam logic [2:0] NOTE_NONE = 3'd0;
    localparam logic [2:0] NOTE_C    = 3'd1;
    localparam logic [2:0] NOTE_D    = 3'd2;
    localparam logic [2:0] NOTE_E    = 3'd3;
    localparam logic [2:0] NOTE_F    = 3'd4;
    localparam logic [2:0] NOTE_G    = 3'd5;
    localparam logic [2:0] NOTE_A    = 3'd6;
    localparam logic [2:0] NOTE_B    = 3'd7;

    // Active-low patterns, bit order .GFEDCBA
    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_DASH  = 8'hBF;

    localparam logic [7:0] GLYPH_C = 8'hC6;
    localparam logic [7:0] GLYPH_D = 8'hA1;
    localparam logic [7:0] GLYPH_E = 8'h86;
    localparam logic [7:0] GLYPH_F = 8'h8E;
    localparam logic [7:0] GLYPH_G = 8'hC2;
    localparam logic [7:0] GLYPH_A = 8'h88;
    localparam logic [7:0] GLYPH_B = 8'h83;

    localparam logic [7:0] GLYPH_0 = 8'hC0;
    localparam logic [7:0] GLYPH_1 = 8'hF9;
    localparam logic [7:0] GLYPH_2 = 8'hA4;
    localparam logic [7:0] GLYPH_3 = 8'hB0;
    localparam logic [7:0] GLYPH_4 = 8'h99;
    localparam logic [7:0] GLYPH_5 = 8'h92;
    localparam logic [7:0] GLYPH_6 = 8'h82;
    localparam logic [7:0] GLYPH_7 = 8'hF8;
    localparam logic [7:0] GLYPH_8 = 8'h80;
    localparam logic [7:0] GLYPH_9 = 8'h90;

    localparam int DP_BIT = 7;

    typedef enum logic [1:0] {
        DIG_OCTAVE,
        DIG_LETTER,
        DIG_HISTORY
    } digit_role_e;

    function automatic digit_role_e digit_role(input int idx);
        if (idx == 0)
            return DIG_OCTAVE;
        else if (idx == 1)
            return DIG_LETTER;
        else
            return DIG_HISTORY;
    endfunction

endpackage

// File: rtl/note_display_scan_glyph.sv
// Combinational seven-segment lookup: numerals (dash above 9) or note letters (0 is blank).
module seg7_glyph
    import note_display_pkg::*;
(
    input  logic       is_digit,
    input  logic [3:0] value,
    input  logic       dp,
    output logic [7:0] seg
);

    logic [7:0] base;

    always_comb begin
        base = SEG_BLANK;
        if (is_digit) begin
            case (value)
                4'd0:    base = GLYPH_0;
                4'd1:    base = GLYPH_1;
                4'd2:    base = GLYPH_2;
                4'd3:    base = GLYPH_3;
                4'd4:    base = GLYPH_4;
                4'd5:    base = GLYPH_5;
                4'd6:    base = GLYPH_6;
                4'd7:    base = GLYPH_7;
                4'd8:    base = GLYPH_8;
                4'd9:    base = GLYPH_9;
                default: base = SEG_DASH;
            endcase
        end else begin
            case (value)
                {1'b0, NOTE_C}: base = GLYPH_C;
                {1'b0, NOTE_D}: base = GLYPH_D;
                {1'b0, NOTE_E}: base = GLYPH_E;
                {1'b0, NOTE_F}: base = GLYPH_F;
                {1'b0, NOTE_G}: base = GLYPH_G;
                {1'b0, NOTE_A}: base = GLYPH_A;
                {1'b0, NOTE_B}: base = GLYPH_B;
                default:        base = SEG_BLANK;
            endcase
        end
        seg = base;
        if (dp)
            seg[DP_BIT] = 1'b0;
    end

endmodule

// File: rtl/note_display_scan.sv
// Multiplexed seven-segment driver: octave, current note letter with sharp dot,
// and a shift history of earlier notes; released notes are held, optionally blinking.
module note_display_scan
    import note_display_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int SCAN_DIV    = 100000,
    parameter int HOLD_CYCLES = 50000000,
    parameter int BLINK_DIV   = 12500000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [2:0]            note,
    input  logic [3:0]            octave,
    input  logic                  sharp,
    input  logic                  blink_en,
    output logic [7:0]            seg,
    output logic [NUM_DIGITS-1:0] an
);

    // With only two digits there is no visible history; keep one unused slot.
    localparam int HIST_D  = (NUM_DIGITS > 2) ? NUM_DIGITS - 2 : 1;
    localparam int DIG_W   = $clog2(NUM_DIGITS);
    localparam int SCAN_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int HOLD_W  = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [2:0]         note_q;
    logic [2:0]         cur_note;
    logic [3:0]         cur_oct;
    logic               cur_sharp;
    logic [2:0]         hist [HIST_D];
    logic               holding;
    logic [HOLD_W-1:0]  hold_cnt;
    logic [SCAN_W-1:0]  scan_cnt;
    logic [DIG_W-1:0]   dig_idx;
    logic [BLINK_W-1:0] blink_cnt;
    logic               blink_ph;

    logic press;
    logic release_ev;

    assign press      = (note != NOTE_NONE) && (note != note_q);
    assign release_ev = (note == NOTE_NONE) && (note_q != NOTE_NONE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            note_q    <= NOTE_NONE;
            cur_note  <= NOTE_NONE;
            cur_oct   <= '0;
            cur_sharp <= 1'b0;
            holding   <= 1'b0;
            hold_cnt  <= '0;
            for (int k = 0; k < HIST_D; k++)
                hist[k] <= NOTE_NONE;
        end else begin
            note_q <= note;
            if (press) begin
                // A re-press during hold still pushes the held note.
                if (cur_note != NOTE_NONE) begin
                    for (int k = HIST_D - 1; k > 0; k--)
                        hist[k] <= hist[k-1];
                    hist[0] <= cur_note;
                end
                cur_note  <= note;
                cur_oct   <= octave;
                cur_sharp <= sharp;
                holding   <= 1'b0;
                hold_cnt  <= '0;
            end else if (release_ev) begin
                holding  <= 1'b1;
                hold_cnt <= '0;
            end else if (holding) begin
                if (hold_cnt == HOLD_W'(HOLD_CYCLES - 1)) begin
                    cur_note <= NOTE_NONE;
                    holding  <= 1'b0;
                end else begin
                    hold_cnt <= hold_cnt + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scan_cnt  <= '0;
            dig_idx   <= '0;
            blink_cnt <= '0;
            blink_ph  <= 1'b0;
        end else begin
            if (scan_cnt == SCAN_W'(SCAN_DIV - 1)) begin
                scan_cnt <= '0;
                if (dig_idx == DIG_W'(NUM_DIGITS - 1))
                    dig_idx <= '0;
                else
                    dig_idx <= dig_idx + 1'b1;
            end else begin
                scan_cnt <= scan_cnt + 1'b1;
            end

            if (blink_cnt == BLINK_W'(BLINK_DIV - 1)) begin
                blink_cnt <= '0;
                blink_ph  <= ~blink_ph;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end

    digit_role_e role;
    logic [2:0]  hist_sel;
    logic        g_is_digit;
    logic [3:0]  g_value;
    logic        g_dp;
    logic        force_blank;
    logic [7:0]  glyph;

    always_comb begin
        hist_sel = NOTE_NONE;
        for (int i = 0; i < HIST_D; i++)
            if (NUM_DIGITS > 2 && int'(dig_idx) == i + 2)
                hist_sel = hist[i];

        role        = digit_role(int'(dig_idx));
        g_is_digit  = 1'b0;
        g_value     = '0;
        g_dp        = 1'b0;
        force_blank = 1'b0;
        case (role)
            DIG_OCTAVE: begin
                g_is_digit  = 1'b1;
                g_value     = cur_oct;
                force_blank = (cur_note == NOTE_NONE);
            end
            DIG_LETTER: begin
                g_value     = {1'b0, cur_note};
                g_dp        = cur_sharp;
                force_blank = (cur_note == NOTE_NONE) || (holding && blink_en && blink_ph);
            end
            default: begin
                g_value = {1'b0, hist_sel};
            end
        endcase
    end

    seg7_glyph u_glyph (
        .is_digit (g_is_digit),
        .value    (g_value),
        .dp       (g_dp),
        .seg      (glyph)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            seg <= SEG_BLANK;
            an  <= '1;
        end else begin
            seg <= force_blank ? SEG_BLANK : glyph;
            an  <= ~(NUM_DIGITS'(1) << dig_idx);
        end
    end

endmodule
